// File: rtl/ddr2_wr_burst_ctrl.sv
// ddr2_wr_burst_ctrl: pops one WRITE_BURST from the write FIFO, packs word pairs into the DDR2 write-data FIFO, then issues one write command.
// Optional burst statistics counter enabled by DDR2_WR_BURST_STATS_EN.
module ddr2_wr_burst_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int WRITE_BURST = 8,
  parameter int ADDR_WIDTH = 31,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(8),
  parameter logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(31'h0FFF_FFF8)
) (
  input  logic                      rd_clk,
  input  logic                      reset,
  input  logic                      phy_init_done,
  input  logic                      wr_enable,
  input  logic                      prog_empty,
  input  logic [DATA_WIDTH-1:0]     data_out,
  input  logic                      dout_vd,
  input  logic                      app_af_afull,
  input  logic                      app_wdf_afull,
  output logic                      rd_fifo,
  output logic                      app_af_wren,
  output logic [2:0]                app_af_cmd,
  output logic [ADDR_WIDTH-1:0]     app_af_addr,
  output logic                      app_wdf_wren,
  output logic [2*DATA_WIDTH-1:0]   app_wdf_data,
  output logic [2*DATA_WIDTH/8-1:0] app_wdf_mask_data,
  output logic                      busy,
  output logic [31:0]               burst_cnt
);
  localparam int CW = $clog2(WRITE_BURST + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, CMD} state_t;
  state_t state, nxt;
  logic [CW-1:0] rd_cnt, d_cnt;
  logic [DATA_WIDTH-1:0] lo;
  logic start, vd;
  always_comb begin
    start = phy_init_done & wr_enable & ~prog_empty & ~app_af_afull & ~app_wdf_afull;
    vd = dout_vd & (state == READ || state == DRAIN);
    nxt = state == IDLE  ? (start ? READ : IDLE) :
          state == READ  ? (rd_cnt == CW'(WRITE_BURST - 1) ? DRAIN : READ) :
          state == DRAIN ? (d_cnt == CW'(WRITE_BURST) ? CMD : DRAIN) : IDLE;
  end
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state <= IDLE;
      rd_cnt <= '0;
      d_cnt <= '0;
      lo <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_af_addr <= ADDR_BASE;
    end else begin
      state <= nxt;
      rd_cnt <= state == READ ? rd_cnt + CW'(1) : '0;
      d_cnt <= state == IDLE ? '0 : d_cnt + CW'(vd);
      app_wdf_wren <= vd & d_cnt[0];
      if (vd & ~d_cnt[0]) lo <= data_out;
      if (vd & d_cnt[0]) app_wdf_data <= {data_out, lo};
      if (state == CMD) app_af_addr <= app_af_addr == ADDR_LAST ? ADDR_BASE : app_af_addr + ADDR_INC;
    end
  end
  assign rd_fifo = state == READ;
  assign app_af_wren = state == CMD;
  assign busy = state != IDLE;
  assign app_af_cmd = 3'b000;
  assign app_wdf_mask_data = '0;
`ifdef DDR2_WR_BURST_STATS_EN
  logic [31:0] cnt;
  always_ff @(posedge rd_clk) begin
    if (reset) cnt <= '0;
    else if (state == CMD && ~&cnt) cnt <= cnt + 32'd1;
  end
  assign burst_cnt = cnt;
`else
  assign burst_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ddr2_wr_burst_ctrl.sv
// tb_ddr2_wr_burst_ctrl: directed bench with a 1-cycle-latency write FIFO model; wrap point lowered to 16.
module tb_ddr2_wr_burst_ctrl;
  logic clk = 1'b0;
  logic reset, phy_init_done, wr_enable, prog_empty, dout_vd, app_af_afull, app_wdf_afull;
  logic [63:0] data_out;
  logic rd_fifo, app_af_wren, app_wdf_wren, busy;
  logic [2:0] app_af_cmd;
  logic [30:0] app_af_addr;
  logic [127:0] app_wdf_data;
  logic [15:0] app_wdf_mask_data;
  logic [31:0] burst_cnt;
  logic [63:0] q[$];
  int checks = 0;
  int errors = 0;
`ifdef DDR2_WR_BURST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  ddr2_wr_burst_ctrl #(.ADDR_LAST(31'd16)) dut (
    .rd_clk(clk), .reset(reset), .phy_init_done(phy_init_done), .wr_enable(wr_enable),
    .prog_empty(prog_empty), .data_out(data_out), .dout_vd(dout_vd),
    .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull), .rd_fifo(rd_fifo),
    .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;
  assign prog_empty = q.size() < 8;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      dout_vd <= 1'b0;
      data_out <= '0;
    end else begin
      dout_vd <= rd_fifo && q.size() > 0;
      if (rd_fifo && q.size() > 0) data_out <= q.pop_front();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] base);
    for (int k = 0; k < 8; k++) q.push_back(base + 64'(k));
  endtask

  // Called in the start-decision cycle T; steps through T+1 .. T+12.
  task automatic run_burst(input logic [63:0] base, input logic [30:0] addr, input logic [30:0] next_addr, input bit disrupt);
    logic [63:0] w;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("rd_fifo", rd_fifo, (i >= 1 && i <= 8) ? 1 : 0);
      chk("busy", busy, i <= 11 ? 1 : 0);
      chk("wdf_wren", app_wdf_wren, (i == 4 || i == 6 || i == 8 || i == 10) ? 1 : 0);
      chk("af_wren", app_af_wren, i == 11 ? 1 : 0);
      if (i == 4 || i == 6 || i == 8 || i == 10) begin
        w = base + 64'(i - 4);
        chk("wdf_data", app_wdf_data, {w + 64'd1, w});
      end
      if (i == 11) begin
        chk("af_addr", 128'(app_af_addr), 128'(addr));
        chk("af_cmd", 128'(app_af_cmd), 128'd0);
      end
      if (i == 12) chk("next_addr", 128'(app_af_addr), 128'(next_addr));
      if (disrupt && i == 3) begin
        app_wdf_afull = 1'b1;
        app_af_afull = 1'b1;
        wr_enable = 1'b0;
        phy_init_done = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    phy_init_done = 1'b1;
    wr_enable = 1'b1;
    app_af_afull = 1'b0;
    app_wdf_afull = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rd_fifo", rd_fifo, 0);
      chk("idle_busy", busy, 0);
      chk("idle_addr", 128'(app_af_addr), 128'd0);
    end
    chk("rst_wdf_data", app_wdf_data, 128'd0);
    chk("rst_wdf_wren", app_wdf_wren, 0);
    chk("rst_af_wren", app_af_wren, 0);
    chk("rst_burst_cnt", 128'(burst_cnt), 128'd0);
    chk("mask", 128'(app_wdf_mask_data), 128'd0);

    push(64'd1);
    run_burst(64'd1, 31'd0, 31'd8, 1'b0);
    chk("cnt1", 128'(burst_cnt), STATS ? 128'd1 : 128'd0);

    push(64'd9);
    push(64'd17);
    run_burst(64'd9, 31'd8, 31'd16, 1'b0);
    run_burst(64'd17, 31'd16, 31'd0, 1'b0);
    chk("cnt3", 128'(burst_cnt), STATS ? 128'd3 : 128'd0);

    app_wdf_afull = 1'b1;
    push(64'd25);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("afull_hold", busy, 0);
      chk("afull_rd", rd_fifo, 0);
    end
    app_wdf_afull = 1'b0;
    run_burst(64'd25, 31'd0, 31'd8, 1'b1);

    push(64'd33);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("disabled_hold", busy, 0);
    end
    app_wdf_afull = 1'b0;
    app_af_afull = 1'b0;
    wr_enable = 1'b1;
    phy_init_done = 1'b1;
    run_burst(64'd33, 31'd8, 31'd16, 1'b0);
    chk("cnt5", 128'(burst_cnt), STATS ? 128'd5 : 128'd0);

    push(64'd41);
    repeat (5) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("rst_rd_fifo", rd_fifo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_addr", 128'(app_af_addr), 128'd0);
    chk("rst_data", app_wdf_data, 128'd0);
    chk("rst_cnt", 128'(burst_cnt), 128'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_af", app_af_wren, 0);
      chk("post_rst_rd", rd_fifo, 0);
    end
    push(64'd49);
    run_burst(64'd49, 31'd0, 31'd8, 1'b0);
    chk("cnt_after_rst", 128'(burst_cnt), STATS ? 128'd1 : 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr2_wr_burst_ctrl.md
# ddr2_wr_burst_ctrl

Write-path burst controller sitting directly downstream of the write FIFO, in the FIFO read-clock domain. When the FIFO holds at least one full burst (`prog_empty` low), the block pops exactly `WRITE_BURST` words and packs word pairs into the DDR2 controller's write-data FIFO. It then issues one write command per burst on the address FIFO, advancing a wrapping linear address.

## Interface
Parameters:
- `DATA_WIDTH`, 64, FIFO word width; the app data bus is 2×`DATA_WIDTH`.
- `WRITE_BURST`, 8, FIFO words per burst; must be even, ≥2.
- `ADDR_WIDTH`, 31, app address width.
- `ADDR_BASE`, 0, first burst address and the wrap target.
- `ADDR_INC`, 8, address increment per burst.
- `ADDR_LAST`, 31'h0FFF_FFF8, last legal burst address; the next address after it is `ADDR_BASE`.

Ports (one clock; reset is synchronous and active-high):
- `rd_clk` in 1: block clock, same as FIFO read clock.
- `reset` in 1: synchronous, active-high.
- `phy_init_done` in 1: DDR2 calibration complete; no burst starts while low.
- `wr_enable` in 1: level; no new burst starts while low.
- `prog_empty` in 1: FIFO below one burst.
- `data_out` in `DATA_WIDTH`: FIFO read data.
- `dout_vd` in 1: FIFO read data valid.
- `app_af_afull` in 1: address FIFO almost full.
- `app_wdf_afull` in 1: write-data FIFO almost full.
- `rd_fifo` out 1: FIFO read enable.
- `app_af_wren` out 1: address FIFO write strobe.
- `app_af_cmd` out 3: command, constant 3'b000 (write).
- `app_af_addr` out `ADDR_WIDTH`: burst address.
- `app_wdf_wren` out 1: write-data strobe.
- `app_wdf_data` out 2×`DATA_WIDTH`: packed data.
- `app_wdf_mask_data` out 2×`DATA_WIDTH`/8: constant zero (no masking).
- `busy` out 1: high in any state except IDLE.
- `burst_cnt` out 32: completed bursts (see Configuration).

## Operation
- States:
  - IDLE: leaves when `phy_init_done & wr_enable & ~prog_empty & ~app_af_afull & ~app_wdf_afull`.
  - READ: `rd_fifo` high for exactly `WRITE_BURST` consecutive cycles, driven by a read counter.
  - DRAIN: waits until the `WRITE_BURST`-th `dout_vd` is seen.
  - CMD: one cycle with `app_af_wren`=1, then back to IDLE.
- Afull inputs are sampled only in IDLE. The MIG afull margin (≥`WRITE_BURST`/2 entries) absorbs a burst already in flight; the block never stalls mid-burst.
- Packing: a data counter increments on each `dout_vd`.
  - Even-index word (0,2,…): latched into the low half.
  - Odd-index word: placed in the high half; `app_wdf_data` = {odd, even}, and `app_wdf_wren` pulses the same cycle.
  - Exactly `WRITE_BURST`/2 wdf writes occur per burst.
- `dout_vd` arriving while not in READ or DRAIN is ignored and must not occur in normal operation.
- Address: `app_af_addr` holds the current burst address. It updates on the cycle after CMD: `ADDR_BASE` if it equalled `ADDR_LAST`, otherwise +`ADDR_INC` (truncated to `ADDR_WIDTH`).
- `wr_enable` or `phy_init_done` falling mid-burst has no effect; the burst completes and the block holds in IDLE.
- Reset mid-burst: immediate return to IDLE, partial burst discarded (no command issued), address back to `ADDR_BASE`. FIFO contents are the FIFO's own concern (its reset is shared).

## Timing
- Reset values:
  - `rd_fifo`, `app_af_wren`, `app_wdf_wren`, `busy` = 0.
  - `app_af_addr` = `ADDR_BASE`.
  - `app_wdf_data` = 0.
  - `burst_cnt` = 0.
  - State = IDLE.
- Start condition true at cycle T → state READ and `rd_fifo`=1 at T+1 … T+`WRITE_BURST` (registered output).
- FIFO valid latency is 1 cycle: `dout_vd` appears at T+2 … T+`WRITE_BURST`+1. `app_wdf_wren` is registered, so it pulses at T+4, T+6, …, T+`WRITE_BURST`+2.
- `app_af_wren` at T+`WRITE_BURST`+3; IDLE at T+`WRITE_BURST`+4. The earliest next start decision is that cycle, so a burst occupies `WRITE_BURST`+4 cycles back-to-back.
- `burst_cnt` increments in the cycle after CMD, saturating at 32'hFFFF_FFFF.

## Configuration
- `DDR2_WR_BURST_STATS_EN` defined: `burst_cnt` is implemented as described.
- Undefined: `burst_cnt` is tied to 32'd0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Reset release, `prog_empty`=1 → no `rd_fifo`, `busy`=0, `app_af_addr`=0 indefinitely.
- FIFO model loaded with words 1..8, all enables high → 4 wdf writes: {2,1},{4,3},{6,5},{8,7}. Then one `app_af_wren` with addr 0 at T+11, next addr 8.
- 16 words queued → two back-to-back bursts, commands at addr 0 and 8, second `rd_fifo` run starting at T+13; `burst_cnt`=2 (macro on) / 0 (macro off).
- `app_wdf_afull`=1 with `prog_empty`=0 → block stays in IDLE. Deassert → burst starts the next cycle; raising afull mid-burst does not stall it.
- `ADDR_LAST`=16, 4 bursts → command addresses 0, 8, 16, 0.
- Assert `reset` at T+5 of a burst → outputs at reset values next cycle, no `app_af_wren`. The following burst is issued at addr 0.
